apb_reg_completer: RTL and testbench

APB4 completer (slave) exposing a bank of 32-bit control/status registers to the fabric, with configurable wait states, byte strobes and PSLVERR signalling. It sits directly downstream of the APB interconnect and consumes the shared APB encodings (`pwrite_t`, `pprot_t`, `pslverr_t`). It presents the register contents and per-register write pulses to local logic.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_reg_completer_pkg.sv | 33 +++
 rtl/apb_reg_bank.sv | 51 +++++
 rtl/apb_reg_completer.sv | 166 ++++++++++++++++
 tb/tb_apb_reg_completer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB encodings used across the fabric (interconnect and completers).
package apb_pkg;

    typedef enum logic {
        PWRITE_READ  = 1'b0,
        PWRITE_WRITE = 1'b1
    } pwrite_t;

    typedef enum logic {
        PPROT1_SECURE    = 1'b0,
        PPROT1_NONSECURE = 1'b1
    } pprot1_t;

    typedef struct packed {
        logic    instr;
        pprot1_t nonsecure;
        logic    privileged;
    } pprot_t;

    typedef enum logic {
        PSLVERR_OKAY  = 1'b0,
        PSLVERR_ERROR = 1'b1
    } pslverr_t;

endpackage

// File: rtl/apb_reg_completer_pkg.sv
// Types and helpers for the APB register completer; the shared APB
// encodings (pwrite_t, pprot_t, pslverr_t) come from apb_pkg.
package apb_reg_completer_pkg;
    import apb_pkg::*;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_cmp_state_t;

    // Byte-lane merge: lanes with a set strobe take the new data.
    function automatic logic [APB_DATA_W-1:0] merge_strb(
        input logic [APB_DATA_W-1:0] cur,
        input logic [APB_DATA_W-1:0] wdata,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = cur[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array for the APB completer: strobed writes, write-pulse
// generation and the read multiplexer.
module apb_reg_bank
    import apb_reg_completer_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [APB_DATA_W-1:0]          wr_data,
    input  logic [APB_STRB_W-1:0]          wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [APB_DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*APB_DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    logic [NUM_REGS-1:0][APB_DATA_W-1:0] regs_r;
    logic [NUM_REGS-1:0]                 wr_pulse_r;

    // Register storage and one-cycle write pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_r     <= '0;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= '0;
            if (wr_en) begin
                regs_r[wr_idx]     <= merge_strb(regs_r[wr_idx], wr_data, wr_strb);
                wr_pulse_r[wr_idx] <= 1'b1;
            end
        end
    end

    // Read mux; indices past the bank read as zero.
    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < NUM_REGS) begin
            rd_data = regs_r[rd_idx];
        end else begin
            rd_data = '0;
        end
    end

    assign reg_q  = regs_r;
    assign reg_wr = wr_pulse_r;

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer over a bank of 32-bit registers with wait states and PSLVERR.
// Define APB_REG_COMPLETER_PROT_CHECK_EN to reject non-secure access to SECURE_MASK registers.
module apb_reg_completer
    import apb_pkg::*;
    import apb_reg_completer_pkg::*;
#(
    parameter int                  ADDR_W      = 12,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] SECURE_MASK = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_W-1:0]              paddr,
    input  logic [APB_DATA_W-1:0]          pwdata,
    input  logic [APB_STRB_W-1:0]          pstrb,
    input  logic [2:0]                     pprot,
    output logic [APB_DATA_W-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*APB_DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_cmp_state_t        state_r;
    logic [3:0]            cnt_r;
    logic [ADDR_W-1:0]     addr_r;
    pwrite_t               write_r;
    logic [APB_DATA_W-1:0] wdata_r;
    logic [APB_STRB_W-1:0] strb_r;
    logic                  pready_r;
    pslverr_t              pslverr_r;
    logic [APB_DATA_W-1:0] prdata_r;

    logic [31:0]           word_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  range_err_s;
    logic                  sec_err_s;
    pslverr_t              err_s;
    logic                  commit_s;
    logic [APB_DATA_W-1:0] rd_data_s;

`ifdef APB_REG_COMPLETER_PROT_CHECK_EN
    pprot_t                prot_r;

    // Latched protection attributes for the secure-register check.
    always_ff @(posedge pclk) begin
        if (preset) begin
            prot_r <= '0;
        end else if (state_r == IDLE && psel && !penable) begin
            prot_r <= pprot_t'(pprot);
        end else begin
            prot_r <= prot_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{pprot, SECURE_MASK};
`endif

    // Address and protection decode from the latched setup-phase values.
    always_comb begin
        word_s      = 32'(addr_r[ADDR_W-1:2]);
        idx_s       = word_s[IDX_W-1:0];
        range_err_s = (addr_r[1:0] != 2'b00) || (word_s >= 32'(NUM_REGS));
`ifdef APB_REG_COMPLETER_PROT_CHECK_EN
        sec_err_s   = !range_err_s && (prot_r.nonsecure == PPROT1_NONSECURE) && SECURE_MASK[idx_s];
`else
        sec_err_s   = 1'b0;
`endif
        if (range_err_s || sec_err_s) begin
            err_s = PSLVERR_ERROR;
        end else begin
            err_s = PSLVERR_OKAY;
        end
        commit_s = (state_r == RESP) && (write_r == PWRITE_WRITE) && (err_s == PSLVERR_OKAY);
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (pclk),
        .rst     (preset),
        .wr_en   (commit_s),
        .wr_idx  (idx_s),
        .wr_data (wdata_r),
        .wr_strb (strb_r),
        .rd_idx  (idx_s),
        .rd_data (rd_data_s),
        .reg_q   (reg_q),
        .reg_wr  (reg_wr)
    );

    // Transfer FSM; response outputs are registered and nonzero only in RESP.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= '0;
            write_r   <= PWRITE_READ;
            wdata_r   <= '0;
            strb_r    <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= PSLVERR_OKAY;
            prdata_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= PSLVERR_OKAY;
                    prdata_r  <= '0;
                    // penable without a preceding setup phase is ignored.
                    if (psel && !penable) begin
                        addr_r  <= paddr;
                        write_r <= pwrite_t'(pwrite);
                        wdata_r <= pwdata;
                        strb_r  <= pstrb;
                        cnt_r   <= 4'(WAIT_STATES);
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_r <= IDLE;
                    end else if (cnt_r == 4'd0) begin
                        pready_r  <= 1'b1;
                        pslverr_r <= err_s;
                        if (write_r == PWRITE_READ && err_s == PSLVERR_OKAY) begin
                            prdata_r <= rd_data_s;
                        end else begin
                            prdata_r <= '0;
                        end
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= PSLVERR_OKAY;
                    prdata_r  <= '0;
                    state_r   <= IDLE;
                end
                default: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= PSLVERR_OKAY;
                    prdata_r  <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign pready  = pready_r;
    assign pslverr = pslverr_r;
    assign prdata  = prdata_r;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: one instance with no wait states
// (secure mask 0x01) and one with three wait states, sharing the bus wires.
module tb_apb_reg_completer;

`ifdef APB_REG_COMPLETER_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic         pclk = 1'b0;
    logic         preset;
    logic         psel, penable, pwrite, use3;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;

    logic         psel0, psel3;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [255:0] reg_q0, reg_q3;
    logic [7:0]   reg_wr0, reg_wr3;

    logic         pready_m, pslverr_m;
    logic [31:0]  prdata_m;

    int           n_pass = 0;
    int           n_total = 0;
    logic [31:0]  rd;
    logic         err;
    int           lat;
    logic         seen;

    always #5 pclk = ~pclk;

    assign psel0     = psel & ~use3;
    assign psel3     = psel & use3;
    assign pready_m  = use3 ? pready3 : pready0;
    assign pslverr_m = use3 ? pslverr3 : pslverr0;
    assign prdata_m  = use3 ? prdata3 : prdata0;

    apb_reg_completer #(
        .ADDR_W(12), .NUM_REGS(8), .WAIT_STATES(0), .SECURE_MASK(8'h01)
    ) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .reg_q(reg_q0), .reg_wr(reg_wr0)
    );

    apb_reg_completer #(
        .ADDR_W(12), .NUM_REGS(8), .WAIT_STATES(3), .SECURE_MASK(8'h00)
    ) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .reg_q(reg_q3), .reg_wr(reg_wr3)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full transfer; returns at the cycle after RESP with the bus idle.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rdo, output logic erro, output int lato);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = d; pstrb = s; pprot = p;
        tick();
        penable = 1'b1;
        lato = -1; rdo = 32'h0; erro = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (pready_m) begin
                lato = n; rdo = prdata_m; erro = pslverr_m;
                break;
            end
            tick();
        end
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic watch_pready(input int cycles, output logic s);
        s = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            if (pready_m) s = 1'b1;
            tick();
        end
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; use3 = 1'b0;
        paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        repeat (3) tick();
        preset = 1'b0;

        check("rst_pready",  32'({pready0, pready3}), 32'd0);
        check("rst_pslverr", 32'({pslverr0, pslverr3}), 32'd0);
        check("rst_prdata",  prdata0 | prdata3, 32'h0);
        check("rst_reg_q",   32'(|{reg_q0, reg_q3}), 32'd0);
        check("rst_reg_wr",  32'({reg_wr0, reg_wr3}), 32'h0);

        // Full-word write, pulse, then readback
        xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, lat);
        check("wr1_latency", 32'(lat), 32'd2);
        check("wr1_pslverr", 32'(err), 32'd0);
        check("wr1_reg_q",   reg_q0[63:32], 32'hDEADBEEF);
        check("wr1_pulse",   32'(reg_wr0), 32'h02);
        tick();
        check("wr1_pulse_end", 32'(reg_wr0), 32'h00);
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, err, lat);
        check("rd1_latency", 32'(lat), 32'd2);
        check("rd1_data",    rd, 32'hDEADBEEF);

        // Back-to-back read after write, then partial strobes
        xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, lat);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b000, rd, err, lat);
        check("raw_data",    rd, 32'hFFFFFFFF);
        xfer(1'b1, 12'h008, 32'h11223344, 4'h5, 3'b000, rd, err, lat);
        xfer(1'b0, 12'h008, 32'h0, 4'hF, 3'b000, rd, err, lat);
        check("strb_data",   rd, 32'hFF22FF44);

        // Decode errors
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, rd, err, lat);
        check("oob_pslverr", 32'(err), 32'd1);
        check("oob_prdata",  rd, 32'h0);
        xfer(1'b1, 12'h002, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, lat);
        check("unal_pslverr", 32'(err), 32'd1);
        check("unal_no_pulse", 32'(reg_wr0), 32'h00);
        check("unal_reg0",   reg_q0[31:0], 32'h0);

        // penable without setup is ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h1;
        watch_pready(4, seen);
        psel = 1'b0; penable = 1'b0;
        check("proto_no_pready", 32'(seen), 32'd0);

        // Secure register 0 accessed non-secure, then secure
        xfer(1'b1, 12'h000, 32'h12345678, 4'hF, 3'b010, rd, err, lat);
        check("sec_ns_pslverr", 32'(err), 32'(PROT_EN));
        check("sec_ns_reg0",   reg_q0[31:0], PROT_EN ? 32'h0 : 32'h12345678);
        xfer(1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 3'b000, rd, err, lat);
        check("sec_s_pslverr", 32'(err), 32'd0);
        check("sec_s_reg0",    reg_q0[31:0], 32'hCAFEF00D);

        // Three wait states
        use3 = 1'b1;
        xfer(1'b1, 12'h00C, 32'h55AA55AA, 4'hF, 3'b000, rd, err, lat);
        check("ws3_wr_latency", 32'(lat), 32'd5);
        check("ws3_wr_reg3",    reg_q3[127:96], 32'h55AA55AA);
        check("ws3_wr_pulse",   32'(reg_wr3), 32'h08);
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'b000, rd, err, lat);
        check("ws3_rd_latency", 32'(lat), 32'd5);
        check("ws3_rd_data",    rd, 32'h55AA55AA);

        // Aborted write: psel drops at T+2
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
        pwdata = 32'h0; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        watch_pready(6, seen);
        check("abort_no_pready", 32'(seen), 32'd0);
        check("abort_reg3",      reg_q3[127:96], 32'h55AA55AA);
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'b000, rd, err, lat);
        check("abort_next_latency", 32'(lat), 32'd5);
        check("abort_next_data",    rd, 32'h55AA55AA);

        // Reset during WAIT of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
        pwdata = 32'h77777777; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        watch_pready(6, seen);
        check("rstmid_no_pready", 32'(seen), 32'd0);
        check("rstmid_regs3",     32'(|reg_q3), 32'd0);
        check("rstmid_regs0",     32'(|reg_q0), 32'd0);
        xfer(1'b1, 12'h00C, 32'h13579BDF, 4'hF, 3'b000, rd, err, lat);
        check("rstmid_next_latency", 32'(lat), 32'd5);
        check("rstmid_next_pslverr", 32'(err), 32'd0);
        check("rstmid_next_reg3",    reg_q3[127:96], 32'h13579BDF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
